// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider with IDLE/CALC/DONE sequencing for the execute stage.
// Optional macro DIV_EARLY_OUT_EN: skip CALC for divide-by-zero or |dividend| < |divisor|.
module div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_en,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_src1,
    input  logic [WIDTH-1:0] div_src2,
    input  logic             div_ack,
    input  logic             flush,
    output logic             div_complete,
    output logic [WIDTH-1:0] div_quotient,
    output logic [WIDTH-1:0] div_remainder,
    output logic             div_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] src1_q;
    logic             sign_q_q;
    logic             sign_r_q;
    logic             zero_q;
    logic             complete_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] remo_q;
    logic             busy_q;

    // Operand magnitudes, taken only for signed divides.
    logic             neg1, neg2;
    logic [WIDTH-1:0] abs1, abs2;
    logic             start;
    logic             src2_zero;

    always_comb begin
        neg1      = div_signed & div_src1[WIDTH-1];
        neg2      = div_signed & div_src2[WIDTH-1];
        abs1      = neg1 ? (~div_src1 + ONE) : div_src1;
        abs2      = neg2 ? (~div_src2 + ONE) : div_src2;
        start     = div_en & ~flush;
        src2_zero = (div_src2 == '0);
    end

    // One restoring step: shift {rem, dividend} left, trial-subtract the divisor.
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;

    always_comb begin
        shifted = {rem_q, dvd_q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        qbit    = ~diff[WIDTH+1];
        rem_nxt = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nxt = {dvd_q[WIDTH-2:0], qbit};
        if (zero_q) begin
            fin_q = sign_r_q ? ONE : ONES;
            fin_r = src1_q;
        end else begin
            fin_q = sign_q_q ? (~quo_nxt + ONE) : quo_nxt;
            fin_r = sign_r_q ? (~rem_nxt + ONE) : rem_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            src1_q     <= '0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            zero_q     <= 1'b0;
            complete_q <= 1'b0;
            quot_q     <= '0;
            remo_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sign_q_q <= div_signed & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
                        sign_r_q <= neg1;
                        zero_q   <= src2_zero;
                        src1_q   <= div_src1;
                        dvd_q    <= abs1;
                        dvs_q    <= abs2;
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                        if (src2_zero || (abs1 < abs2)) begin
                            state_q    <= S_DONE;
                            complete_q <= 1'b1;
                            quot_q     <= src2_zero ? (neg1 ? ONE : ONES) : '0;
                            remo_q     <= div_src1;
                        end else begin
                            state_q <= S_CALC;
                        end
`else
                        state_q <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q <= rem_nxt;
                        dvd_q <= quo_nxt;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q    <= S_DONE;
                            complete_q <= 1'b1;
                            quot_q     <= fin_q;
                            remo_q     <= fin_r;
                        end
                    end
                end
                S_DONE: begin
                    // Flush discards the result; ack retires it and keeps the last value visible.
                    if (flush) begin
                        state_q    <= S_IDLE;
                        complete_q <= 1'b0;
                        busy_q     <= 1'b0;
                        quot_q     <= '0;
                        remo_q     <= '0;
                    end else if (div_ack) begin
                        state_q    <= S_IDLE;
                        complete_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    complete_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign div_complete  = complete_q;
    assign div_quotient  = quot_q;
    assign div_remainder = remo_q;
    assign div_busy      = busy_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: scoreboard queue of expected {quotient, remainder}
// pairs, checked against the DUT on completion along with latency and handshake behaviour.
module tb_div_ctrl;

    logic        clk;
    logic        reset;
    logic        div_en;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_ack;
    logic        flush;
    logic        div_complete;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_busy;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .div_en       (div_en),
        .div_signed   (div_signed),
        .div_src1     (div_src1),
        .div_src2     (div_src2),
        .div_ack      (div_ack),
        .flush        (flush),
        .div_complete (div_complete),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .div_busy     (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endfunction

    function automatic int exp_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        logic [31:0] ma, mb;
        ma = (sgn && a[31]) ? (32'd0 - a) : a;
        mb = (sgn && b[31]) ? (32'd0 - b) : b;
        if (b == 32'd0 || ma < mb) return 1;
`endif
        return 33;
    endfunction

    // Drives operands immediately (caller is in the start cycle), waits for completion,
    // holds for `hold` cycles, then acks. Returns at the negedge of the following IDLE cycle.
    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input bit keep_en);
        logic [31:0] eq, er, pq, pr;
        int n;
        model(sgn, a, b, eq, er);
        exp_q.push_back(eq);
        exp_q.push_back(er);
        div_en = 1'b1; div_signed = sgn; div_src1 = a; div_src2 = b;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!div_complete) div_ack = 1'($urandom_range(0, 1));
        end while (!div_complete && n < 100);
        div_ack = 1'b0;
        check_val("latency", 32'(n), 32'(exp_lat(sgn, a, b)));
        pq = exp_q.pop_front();
        pr = exp_q.pop_front();
        if (!div_complete) begin
            div_en = 1'b0;
            return;
        end
        check_val("quotient", div_quotient, pq);
        check_val("remainder", div_remainder, pr);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("hold_complete", 32'(div_complete), 32'd1);
            check_val("hold_quotient", div_quotient, pq);
            check_val("hold_remainder", div_remainder, pr);
        end
        div_ack = 1'b1;
        @(posedge clk);
        #1;
        div_ack = 1'b0;
        if (!keep_en) div_en = 1'b0;
        @(negedge clk);
        check_val("idle_complete", 32'(div_complete), 32'd0);
        check_val("idle_busy", 32'(div_busy), 32'd0);
    endtask

    initial begin
        logic seen;
        reset = 1'b1; div_en = 1'b0; div_signed = 1'b0; div_src1 = '0; div_src2 = '0;
        div_ack = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_complete", 32'(div_complete), 32'd0);
        check_val("rst_busy", 32'(div_busy), 32'd0);
        check_val("rst_quotient", div_quotient, 32'd0);
        check_val("rst_remainder", div_remainder, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_div(1'b0, 32'd100, 32'd7, 0, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_div(1'b0, 32'd5, 32'd0, 0, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF6, 32'd0, 0, 1'b0);
        run_div(1'b0, 32'h8000_0000, 32'd3, 0, 1'b0);
        run_div(1'b1, 32'd3, 32'd10, 0, 1'b0);

        // Hold in DONE, then back-to-back with div_en kept high.
        run_div(1'b0, 32'd100, 32'd7, 5, 1'b1);
        run_div(1'b0, 32'd9, 32'd3, 0, 1'b0);

        // Flush during CALC: result must never appear.
        div_en = 1'b1; div_signed = 1'b0; div_src1 = 32'd100; div_src2 = 32'd7;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; div_en = 1'b0;
        @(negedge clk);
        check_val("flush_busy", 32'(div_busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_complete) seen = 1'b1;
        end
        check_val("flush_no_complete", 32'(seen), 32'd0);
        run_div(1'b0, 32'd20, 32'd6, 0, 1'b0);

        // Flush in IDLE blocks the start.
        div_en = 1'b1; flush = 1'b1; div_src1 = 32'd50; div_src2 = 32'd5;
        @(posedge clk);
        #1 flush = 1'b0; div_en = 1'b0;
        @(negedge clk);
        check_val("idle_flush_busy", 32'(div_busy), 32'd0);

        // Reset mid-CALC clears everything.
        div_en = 1'b1; div_signed = 1'b0; div_src1 = 32'd9; div_src2 = 32'd3;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; div_en = 1'b0;
        @(negedge clk);
        check_val("midrst_busy", 32'(div_busy), 32'd0);
        check_val("midrst_complete", 32'(div_complete), 32'd0);
        check_val("midrst_quotient", div_quotient, 32'd0);
        check_val("midrst_remainder", div_remainder, 32'd0);

        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 28);
            run_div(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2), 1'b0);
        end

        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller plus iterative datapath for the shared 32-bit integer divider used by the execute stage (div.w/mod.w, signed and unsigned).
- Accepts an operand pair from execute, runs a radix-2 restoring division over WIDTH cycles, and holds the result until execute retires the instruction.
- Supports cancellation on pipeline flush.
- Execute stalls on `div_en & ~div_complete`.

Parameters:
- WIDTH, 32, operand/result width in bits. Only 32 is supported for LA32.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- div_en  in  1  execute holds a valid divide; level, held high until retire.
- div_signed  in  1  1 = signed, 0 = unsigned; sampled at start.
- div_src1  in  WIDTH  dividend; sampled at start.
- div_src2  in  WIDTH  divisor; sampled at start.
- div_ack  in  1  execute advances the divide instruction this cycle (es_allowin & es_valid path).
- flush  in  1  cancel any in-flight or completed divide.
- div_complete  out  1  result valid; level, held until ack or flush.
- div_quotient  out  WIDTH  quotient; valid while div_complete is high.
- div_remainder  out  WIDTH  remainder; valid while div_complete is high.
- div_busy  out  1  state is not IDLE.

Behaviour:
- States: IDLE, CALC, DONE. Reset forces IDLE, counter=0, div_complete=0, div_busy=0, div_quotient=0, div_remainder=0.
- IDLE to CALC: when `div_en & ~flush`.
  - Latch sign_q = div_signed & src1[31] ^ src2[31] (quotient sign) and sign_r = div_signed & src1[31] (remainder sign).
  - Latch |src1| and |src2|. Absolute value is taken only when div_signed; 0x80000000 stays 0x80000000 as an unsigned magnitude.
  - Clear the partial remainder; counter = 0.
- CALC, each cycle:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor from rem (WIDTH+1-bit subtract). If non-negative, rem = difference and quotient bit = 1; else quotient bit = 0.
  - counter++. When counter == WIDTH-1, go to DONE.
  - Exactly WIDTH CALC cycles.
- Entering DONE: register final results.
  - quotient = sign_q ? -q : q.
  - remainder = sign_r ? -r : r.
- Latency: start cycle S (IDLE with div_en); CALC occupies cycles S+1..S+32; div_complete is first high in cycle S+33.
- DONE:
  - div_complete = 1.
  - On `div_ack | flush`, go to IDLE and drop div_complete the next cycle.
  - div_ack with div_en still high (back-to-back divide) is not a restart in the same cycle: the IDLE cycle that follows samples the new operands. Worst-case back-to-back throughput is 34 cycles.
  - If div_ack is low, DONE holds indefinitely and outputs stay stable. This covers ms_allowin stalls without restarting the same instruction.
- flush in CALC or DONE: return to IDLE next cycle, drop div_complete, discard results.
- flush in IDLE: blocks the start that cycle.
- flush has priority over div_ack and over start.
- div_en falling in CALC without flush is a protocol violation; the controller still completes and waits in DONE.
- Divide by zero: the algorithm result is forced.
  - Unsigned: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed: quotient = 0xFFFFFFFF (-1) when dividend >= 0, else 0x00000001; remainder = dividend.
  - Latency is the same as a normal divide.
- Signed overflow: 0x80000000 / -1 gives quotient 0x80000000, remainder 0. No trap.
- div_ack outside DONE is ignored.
- Reset asserted mid-CALC returns to IDLE with all outputs cleared next cycle.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined, at start: if divisor == 0, or |dividend| < |divisor| (unsigned magnitude compare), skip CALC and go directly IDLE to DONE. div_complete is high at S+1 with the normal divide-by-zero or {q=0, r=signed dividend} result.
- When undefined, every divide takes the fixed 33-cycle latency. The result values are identical in both builds.

Test Plan:
- Unsigned 100/7, div_ack=1 on completion: div_complete rises at cycle S+33; q=14, r=2; IDLE at S+34.
- Signed -7/2 (0xFFFFFFF9, 0x00000002): q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7/-2: q=0xFFFFFFFD, r=1.
- Signed 0x80000000 / 0xFFFFFFFF: q=0x80000000, r=0.
  - Unsigned 5/0: q=0xFFFFFFFF, r=5.
  - With DIV_EARLY_OUT_EN, the 5/0 case completes at S+1.
- Hold and back-to-back:
  - 100/7 with div_ack low for 5 cycles after completion: div_complete and the results stay stable; ack then gives IDLE.
  - Second divide 9/3, presented with div_en continuously high: q=3, r=0, complete 34 cycles after the first ack.
- Flush at CALC cycle 10: IDLE next cycle, div_complete never asserts. A new 20/6 started right after yields q=3, r=2 with full latency.
